// File: rtl/enc_pkg.sv
// Shared definitions for the round-robin priority encoder.
//   enc_mode_e : selection mode carried alongside each request vector
//   enc_clog2  : index width for an N-bit request vector (minimum 1)
package enc_pkg;

  typedef enum logic [1:0] {
    ENC_MODE_HI   = 2'b00,  // highest set index (legacy "last set bit wins")
    ENC_MODE_LO   = 2'b01,  // lowest set index
    ENC_MODE_RR   = 2'b10,  // round-robin from the pointer upwards, then wrap
    ENC_MODE_RSVD = 2'b11   // reserved, behaves as ENC_MODE_HI
  } enc_mode_e;

  function automatic int enc_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/prio_scan.sv
// Combinational lowest-set-index finder.
//   vec   : input vector to scan
//   idx   : index of the lowest set bit (0 when nothing is set)
//   found : at least one bit of vec is set
module prio_scan
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    idx   = '0;
    found = 1'b0;
    // Scanning downwards lets the lowest set bit be the last (winning) assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N:log2(N) priority encoder with highest, lowest and round-robin
// selection behind valid/ready handshakes on both sides (latency 1).
//   clk, rst_n  : clock, synchronous active-low reset
//   req_valid   : req_vec/mode valid this cycle
//   req_ready   : block can take a request this cycle
//   req_vec     : request bits, bit i = source i requesting
//   mode        : enc_mode_e selection mode, sampled with req_vec
//   out_valid   : result registers hold a result
//   out_ready   : consumer takes the result this cycle
//   out_idx     : selected index
//   out_onehot  : one-hot of out_idx, zero when out_none
//   out_none    : accepted req_vec was all zero
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = enc_clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_vec,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         out_none
);

  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_none;
  logic [W-1:0] r_ptr;

  logic         w_accept;
  enc_mode_e    w_mode;
  logic [N-1:0] w_rr_mask;
  logic [N-1:0] w_vec_masked;
  logic [N-1:0] w_vec_rev;
  logic [W-1:0] w_lo_idx, w_rr_idx, w_rev_idx, w_hi_idx;
  logic         w_lo_found, w_rr_found, w_rev_found;
  logic [W-1:0] w_sel_idx;
  logic [N-1:0] w_sel_onehot;
  logic [W-1:0] w_ptr_next;

  assign req_ready = !r_valid || out_ready;
  assign w_accept  = req_valid && req_ready;
  assign w_mode    = enc_mode_e'(mode);

  // Round-robin mask keeps bits at or above the pointer; the reversed vector
  // turns the lowest-index finder into a highest-index finder.
  always_comb begin
    w_rr_mask = '0;
    w_vec_rev = '0;
    for (int i = 0; i < N; i++) begin
      w_rr_mask[i] = (i >= int'(r_ptr));
      w_vec_rev[i] = req_vec[N-1-i];
    end
  end

  assign w_vec_masked = req_vec & w_rr_mask;

  prio_scan #(.N(N)) u_scan_lo  (.vec(req_vec),      .idx(w_lo_idx),  .found(w_lo_found));
  prio_scan #(.N(N)) u_scan_rr  (.vec(w_vec_masked), .idx(w_rr_idx),  .found(w_rr_found));
  prio_scan #(.N(N)) u_scan_rev (.vec(w_vec_rev),    .idx(w_rev_idx), .found(w_rev_found));

  // w_rev_found always equals w_lo_found; the unmasked scan is the one used as "any set".
  assign w_hi_idx = W'(N - 1) - w_rev_idx;

  always_comb begin
    case (w_mode)
      ENC_MODE_LO: w_sel_idx = w_lo_idx;
      ENC_MODE_RR: w_sel_idx = w_rr_found ? w_rr_idx : w_lo_idx;
      default:     w_sel_idx = w_hi_idx;
    endcase
    // The reversed scan yields N-1 on an empty vector, so force index 0 there.
    if (!w_lo_found) w_sel_idx = '0;
  end

  assign w_sel_onehot = w_lo_found ? (N'(1) << w_sel_idx) : '0;
  // Explicit wrap so the pointer never reaches N when N is not a power of two.
  assign w_ptr_next   = (w_sel_idx == W'(N - 1)) ? '0 : w_sel_idx + W'(1);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_idx    <= '0;
      r_onehot <= '0;
      r_none   <= 1'b0;
      r_ptr    <= '0;
    end else begin
      if (w_accept) begin
        r_valid  <= 1'b1;
        r_idx    <= w_sel_idx;
        r_onehot <= w_sel_onehot;
        r_none   <= !w_lo_found;
        if (w_mode == ENC_MODE_RR && w_lo_found) r_ptr <= w_ptr_next;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign out_idx    = r_idx;
  assign out_onehot = r_onehot;
  assign out_none   = r_none;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: one N=8 instance (A) and one N=6
// instance (B). The driver pushes hand-computed results on each accepted
// request; a negedge monitor compares whatever the DUT presents.
module tb_prio_encoder_rr;

  typedef struct {
    logic [2:0] idx;
    logic [7:0] onehot;
    logic       none;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_wait;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_req_valid, a_req_ready, a_out_valid, a_out_ready, a_out_none;
  logic [7:0] a_req_vec, a_out_onehot;
  logic [1:0] a_mode;
  logic [2:0] a_out_idx;

  logic       b_req_valid, b_req_ready, b_out_valid, b_out_ready, b_out_none;
  logic [5:0] b_req_vec, b_out_onehot;
  logic [1:0] b_mode;
  logic [2:0] b_out_idx;

  prio_encoder_rr #(.N(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_vec(a_req_vec), .mode(a_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_idx(a_out_idx),
    .out_onehot(a_out_onehot), .out_none(a_out_none)
  );

  prio_encoder_rr #(.N(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_vec(b_req_vec), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_idx(b_out_idx),
    .out_onehot(b_out_onehot), .out_none(b_out_none)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare presented output against the scoreboard head; pop on handshake.
  task automatic mon(input bit sel, input logic v, input logic r, input logic [2:0] idx,
                     input logic [7:0] oh, input logic none);
    exp_t  e;
    int    sz;
    string p;
    p  = sel ? "B" : "A";
    sz = sel ? q_b.size() : q_a.size();
    if (v) begin
      if (sz == 0) begin
        check($sformatf("%s unexpected out_valid", p), 32'(v), 32'd0);
      end else begin
        e = sel ? q_b[0] : q_a[0];
        check($sformatf("%s out_idx", p),    32'(idx),  32'(e.idx));
        check($sformatf("%s out_onehot", p), 32'(oh),   32'(e.onehot));
        check($sformatf("%s out_none", p),   32'(none), 32'(e.none));
        if (r) begin
          if (sel) void'(q_b.pop_front());
          else     void'(q_a.pop_front());
        end
      end
    end else if (sz != 0) begin
      check($sformatf("%s out_valid one cycle after accept", p), 32'(v), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(1'b0, a_out_valid, a_out_ready, a_out_idx, a_out_onehot, a_out_none);
      mon(1'b1, b_out_valid, b_out_ready, b_out_idx, {2'b00, b_out_onehot}, b_out_none);
    end
  end

  // Issue one request (called just after a posedge); push its expected result on accept.
  task automatic send(input bit sel, input logic [7:0] vec, input logic [1:0] m,
                      input int idx, input bit none);
    exp_t e;
    logic rdy;
    e.idx    = 3'(idx);
    e.none   = none;
    e.onehot = none ? 8'h00 : (8'h01 << idx);
    if (sel) begin b_req_valid = 1'b1; b_req_vec = vec[5:0]; b_mode = m; end
    else     begin a_req_valid = 1'b1; a_req_vec = vec;      a_mode = m; end
    last_wait = 0;
    @(negedge clk);
    rdy = sel ? b_req_ready : a_req_ready;
    while (!rdy && last_wait < 20) begin
      @(negedge clk);
      last_wait++;
      rdy = sel ? b_req_ready : a_req_ready;
    end
    if (!rdy) begin
      check(sel ? "B req_ready wait" : "A req_ready wait", 32'(rdy), 32'd1);
    end else begin
      @(posedge clk);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    #1;
    if (sel) begin b_req_valid = 1'b0; b_req_vec = 'x; end
    else     begin a_req_valid = 1'b0; a_req_vec = 'x; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_req_valid = 1'b0; a_req_vec = '0; a_mode = 2'b00; a_out_ready = 1'b1;
    b_req_valid = 1'b0; b_req_vec = '0; b_mode = 2'b00; b_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("A reset out_valid",  32'(a_out_valid),  32'd0);
    check("A reset out_idx",    32'(a_out_idx),    32'd0);
    check("A reset out_onehot", 32'(a_out_onehot), 32'd0);
    check("A reset out_none",   32'(a_out_none),   32'd0);
    check("A reset req_ready",  32'(a_req_ready),  32'd1);
    check("B reset out_valid",  32'(b_out_valid),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // A: highest / lowest index on the same vector
    send(0, 8'b0010_0110, 2'b00, 5, 0);
    send(0, 8'b0010_0110, 2'b01, 1, 0);
    // A: round-robin over all-ones, ptr starts at 0 and wraps 7 -> 0 (ends at ptr=1)
    for (int k = 0; k < 9; k++) send(0, 8'hFF, 2'b10, k % 8, 0);
    // A: all-zero vectors in every mode leave ptr at 1
    send(0, 8'h00, 2'b00, 0, 1);
    send(0, 8'h00, 2'b01, 0, 1);
    send(0, 8'h00, 2'b10, 0, 1);
    send(0, 8'h00, 2'b11, 0, 1);
    send(0, 8'h03, 2'b10, 1, 0);  // ptr 1 -> idx 1, ptr 2
    send(0, 8'h03, 2'b10, 0, 0);  // nothing >= 2, wrap -> idx 0, ptr 1
    send(0, 8'b0010_0110, 2'b11, 5, 0);  // reserved mode acts as highest

    // A: backpressure
    repeat (2) @(posedge clk); #1;
    a_out_ready = 1'b0;
    send(0, 8'h0C, 2'b01, 2, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("A req_ready while stalled", 32'(a_req_ready), 32'd0);
      check("A out_valid while stalled", 32'(a_out_valid), 32'd1);
      a_mode    = 2'b00;     // must not disturb the held result
      a_req_vec = 8'hFF;
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    send(0, 8'h0C, 2'b00, 3, 0);  // drain and accept in the same cycle
    check("A drain+accept same cycle", 32'(last_wait), 32'd0);

    // A: reset while holding a result clears outputs and ptr
    repeat (2) @(posedge clk); #1;
    a_out_ready = 1'b0;
    send(0, 8'h04, 2'b10, 2, 0);  // ptr 1 -> idx 2, ptr 3
    @(negedge clk);
    check("A out_valid held before reset", 32'(a_out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    @(posedge clk);
    @(negedge clk);
    check("A out_valid after reset",  32'(a_out_valid),  32'd0);
    check("A out_idx after reset",    32'(a_out_idx),    32'd0);
    check("A out_onehot after reset", 32'(a_out_onehot), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    send(0, 8'h09, 2'b10, 0, 0);  // ptr back to 0 -> idx 0, ptr 1
    send(0, 8'h09, 2'b10, 3, 0);  // ptr 1 -> idx 3

    // B (N=6): highest index on a non-power-of-two width
    send(1, 8'h3F, 2'b00, 5, 0);
    send(1, 8'h06, 2'b00, 2, 0);
    // B: advance ptr to 4, then wrap on a low-only vector
    for (int k = 0; k < 4; k++) send(1, 8'h3F, 2'b10, k, 0);
    send(1, 8'h03, 2'b10, 0, 0);  // ptr 4: nothing >= 4, wrap -> idx 0, ptr 1
    send(1, 8'h03, 2'b10, 1, 0);  // ptr 1 -> idx 1, ptr 2
    send(1, 8'h10, 2'b10, 4, 0);  // idx 4 -> ptr 5
    send(1, 8'h21, 2'b10, 5, 0);  // ptr 5 -> idx 5, ptr wraps to 0
    send(1, 8'h00, 2'b10, 0, 1);  // empty, ptr unchanged
    send(1, 8'h3E, 2'b10, 1, 0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("A scoreboard drained", 32'(q_a.size()), 32'd0);
    check("B scoreboard drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
